muldiv_unit: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Replaces the combinational negedge HI/LO update in the current ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) behind a start/busy/done handshake.
- Also services MTHI/MTLO writes; HI/LO are readable combinationally for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, with atomic HI/LO commit in the FIX state.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [CNTW-1:0]    cnt;
    logic               is_div;
    logic               dz_pend;
    logic               sign_q;
    logic               sign_r;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   rem;

    logic               is_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // work holds {accumulator, multiplier} for multiply and the shifting dividend/quotient for divide
    always_comb begin
        is_signed = ~op[0];
        sa        = is_signed & a[WIDTH-1];
        sb        = is_signed & b[WIDTH-1];
        abs_a     = sa ? (~a + 1'b1) : a;
        abs_b     = sb ? (~b + 1'b1) : b;
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag_a} : '0);
        shifted   = {rem, work[WIDTH-1]};
        diff      = shifted - {1'b0, mag_b};
        fits      = (shifted >= {1'b0, mag_b});
        prod_fix  = sign_q ? (~work + 1'b1) : work;
        quo_fix   = sign_q ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
        rem_fix   = sign_r ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            dz_pend     <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            work        <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        is_div      <= op[1];
                        sign_q      <= sa ^ sb;
                        sign_r      <= sa;
                        mag_a       <= abs_a;
                        mag_b       <= abs_b;
                        rem         <= '0;
                        dz_pend     <= 1'b0;
                        cnt         <= CNTW'(WIDTH);
                        state       <= CALC;
                        if (op[1]) begin
                            work <= {{WIDTH{1'b0}}, abs_a};
                            // Divide by zero skips iteration; keep raw a for HI
                            if (b == '0) begin
                                dz_pend <= 1'b1;
                                work    <= {{WIDTH{1'b0}}, a};
                                cnt     <= '0;
                                state   <= FIX;
                            end
                        end else begin
                            work <= {{WIDTH{1'b0}}, abs_b};
                        end
                    end else if (start && !op[1]) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNTW'(1)) state <= FIX;
                        if (is_div) begin
                            rem               <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                            work[WIDTH-1:0]   <= {work[WIDTH-2:0], fits};
                        end else begin
                            work <= {mul_sum, work[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (dz_pend) begin
                            hi          <= work[WIDTH-1:0];
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard built from native SV arithmetic.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int   total;
    int   bad;
    exp_t sb_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from plain SV integer arithmetic
    function automatic exp_t model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        exp_t        r;
        logic [63:0] p;
        int          sa;
        int          sb;
        r  = '0;
        sa = ma;
        sb = mb;
        case (mop)
            OP_MULT: begin
                p = 64'($signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb}));
                {r.hi, r.lo} = p;
            end
            OP_MULTU: begin
                p = {32'b0, ma} * {32'b0, mb};
                {r.hi, r.lo} = p;
            end
            OP_DIV, OP_DIVU: begin
                if (mb == 32'b0) begin
                    r.dz = 1'b1;
                    r.hi = ma;
                    r.lo = 32'hFFFF_FFFF;
                end else if (mop == OP_DIVU) begin
                    r.lo = ma / mb;
                    r.hi = ma % mb;
                end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000;
                    r.hi = 32'h0;
                end else begin
                    r.lo = 32'(sa / sb);
                    r.hi = 32'(sa % sb);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one start pulse from a negedge; returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic [2:0] sop, input logic [31:0] sa, input logic [31:0] sb, input bit push);
        start = 1'b1;
        op    = sop;
        a     = sa;
        b     = sb;
        if (push) sb_q.push_back(model(sop, sa, sb));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int exp_lat, input int exp_busy);
        int   n;
        int   bc;
        exp_t e;
        n  = 0;
        bc = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, {63'b0, done}, 64'd1);
        if (done === 1'b1) begin
            checkOutput({tag, "_latency"}, 64'(n), 64'(exp_lat));
            checkOutput({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
            checkOutput({tag, "_sb_nonempty"}, {63'b0, sb_q.size() != 0}, 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
                checkOutput({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
                checkOutput({tag, "_dz"}, {63'b0, div_by_zero}, {63'b0, e.dz});
            end
        end
    endtask

    initial begin
        bit saw_done;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b0;
        a       = 32'b0;
        b       = 32'b0;
        cancel  = 1'b0;

        #12;
        checkOutput("reset_state", {29'b0, busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] MULT -3*7");
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        checkOutput("mult_busy_after_start", {63'b0, busy}, 64'd1);
        checkOutput("mult_hilo_held", {hi, lo}, 64'd0);
        waitDone("mult_neg", 33, 33);
        checkOutput("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        checkOutput("done_one_cycle", {63'b0, done}, 64'd0);

        $display("[TB] MULTU / MULT all ones");
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        waitDone("multu_max", 33, 33);
        checkOutput("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        waitDone("mult_m1m1", 33, 33);

        $display("[TB] DIV signed and overflow");
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitDone("div_neg", 33, 33);
        checkOutput("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDone("div_ovf", 33, 33);
        checkOutput("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        $display("[TB] DIVU by zero");
        applyStimulus(OP_DIVU, 32'd100, 32'd0, 1'b1);
        waitDone("divu_zero", 1, 1);
        @(negedge clk);
        checkOutput("dz_sticky", {63'b0, div_by_zero}, 64'd1);
        applyStimulus(OP_MULTU, 32'd5, 32'd6, 1'b1);
        checkOutput("dz_cleared_by_start", {63'b0, div_by_zero}, 64'd0);
        waitDone("multu_small", 33, 33);

        $display("[TB] MTHI / MTLO");
        applyStimulus(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        checkOutput("mthi", {30'b0, busy, done, hi}, 64'h1234);
        applyStimulus(OP_MTLO, 32'h5678, 32'd0, 1'b0);
        checkOutput("mtlo", {30'b0, busy, done, lo}, 64'h5678);

        $display("[TB] cancel with ignored restart");
        applyStimulus(OP_MULTU, 32'd3, 32'd4, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_during_restart", {63'b0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("cancel_busy", {63'b0, busy}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        checkOutput("cancel_no_done", {63'b0, saw_done}, 64'd0);
        checkOutput("cancel_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

        $display("[TB] async reset mid DIVU");
        applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b0);
        repeat (13) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset", {29'b0, busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b1);
        waitDone("divu_1000_7", 33, 33);
        checkOutput("divu_const", {hi, lo}, {32'd6, 32'd142});
        applyStimulus(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
        checkOutput("b2b_accepted", {63'b0, busy}, 64'd1);
        waitDone("div_b2b", 33, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
